dbus_responder: RTL and testbench

Data-bus responder on the memory end of the ARM core's data port. Accepts single-word load/store requests through a req/ready handshake with a configurable number of wait states, and serves them from an internal word RAM. Decodes a small memory-mapped window: a sticky "done" mailbox that replaces address-compare logic in benches, and a free-running cycle counter. Flags unaligned or unmapped accesses with an error response.

---
 rtl/dbus_responder.sv | 141 ++++++++++++++
 tb/tb_dbus_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// dbus_responder: single-word load/store responder for the core data port.
// Requests are accepted from IDLE, held for WAIT_CYCLES wait states, then
// answered with a one-cycle ready strobe. Serves an internal word RAM, a
// sticky "done" mailbox and a free-running cycle counter; anything unaligned
// or outside those regions gets an error response.
module dbus_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_07F8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        done,
  output logic [31:0] done_code
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd4;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        wait_cnt_reg;
  logic              we_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       cycle_cnt_reg;
  logic [31:0]       cycle_snap_reg;
  logic              done_reg;
  logic [31:0]       done_code_reg;
  logic [31:0]       ram [DEPTH_WORDS];
  logic [31:0]       ram_q;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              dec_err, dec_ram, dec_mbox, dec_cnt;

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and response outputs (outputs are zero outside RESP).
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    rdata      = 32'd0;
    err        = 1'b0;
    case (state_reg)
      IDLE: if (req) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt_reg == 8'd1) state_next = RESP;
      RESP: begin
        state_next = IDLE;
        ready      = 1'b1;
        err        = dec_err;
        if (!we_reg && !dec_err) begin
          if (dec_ram)       rdata = ram_q;
          else if (dec_mbox) rdata = done_code_reg;
          else if (dec_cnt)  rdata = cycle_snap_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the request on acceptance and count down the wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      wait_cnt_reg <= 8'd0;
    end else if (state_reg == IDLE && req) begin
      we_reg       <= we;
      addr_reg     <= addr;
      wdata_reg    <= wdata;
      wait_cnt_reg <= WAIT_INIT;
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg - 8'd1;
    end
  end

  // Address decode of the latched request; first match wins.
  always_comb begin
    dec_err  = 1'b0;
    dec_ram  = 1'b0;
    dec_mbox = 1'b0;
    dec_cnt  = 1'b0;
    if (addr_reg[1:0] != 2'b00)      dec_err  = 1'b1;
    else if (addr_reg < RAM_BYTES)   dec_ram  = 1'b1;
    else if (addr_reg == MMIO_BASE)  dec_mbox = 1'b1;
    else if (addr_reg == CNT_ADDR)   dec_cnt  = 1'b1;
    else                             dec_err  = 1'b1;
  end

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // RAM read must use the live address while still in IDLE.
  assign rd_idx = (state_reg == IDLE) ? addr[IDX_W+1:2] : addr_reg[IDX_W+1:2];
  assign wr_idx = addr_reg[IDX_W+1:2];

  // Word RAM: registered read every cycle, store commits on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (state_reg == RESP && we_reg && dec_ram) ram[wr_idx] <= wdata_reg;
    ram_q <= ram[rd_idx];
  end

  // Free-running cycle counter, snapshotted on entry to RESP for counter loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_reg  <= 32'd0;
      cycle_snap_reg <= 32'd0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (state_next == RESP && state_reg != RESP) cycle_snap_reg <= cycle_cnt_reg;
    end
  end

  // Sticky done mailbox, written by a store to MMIO_BASE as it leaves RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_reg      <= 1'b0;
      done_code_reg <= 32'd0;
    end else if (state_reg == RESP && we_reg && dec_mbox) begin
      done_reg      <= 1'b1;
      done_code_reg <= wdata_reg;
    end
  end

  assign done      = done_reg;
  assign done_code = done_code_reg;

endmodule

// File: tb/tb_dbus_responder.sv
// Testbench for dbus_responder: directed table, randomized traffic against a
// behavioural model, reset-during-wait and zero-wait-state sequences.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ready, err, done;
  logic [31:0] rdata, done_code;
  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic        ready0, err0, done0;
  logic [31:0] rdata0, done_code0;

  int n_cmp  = 0;
  int n_fail = 0;
  int stray  = 0;

  always #5 clk = ~clk;

  dbus_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .MMIO_BASE(32'h7F8)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .err(err), .done(done), .done_code(done_code)
  );

  dbus_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .MMIO_BASE(32'h7F8)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rdata(rdata0), .err(err0), .done(done0), .done_code(done_code0)
  );

  // Behavioural model of the memory map.
  logic [31:0] m_mem [64];
  bit          m_val [64];
  bit          m_done;
  logic [31:0] m_code;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // 0 = error, 1 = RAM, 2 = mailbox, 3 = counter
  function automatic int kind(input logic [31:0] a);
    if (a % 4 != 0)      return 0;
    if (a < 32'd256)     return 1;
    if (a == 32'h7F8)    return 2;
    if (a == 32'h7FC)    return 3;
    return 0;
  endfunction

  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
    if (w && kind(a) == 1) begin
      m_mem[a / 4] = d;
      m_val[a / 4] = 1'b1;
    end
    if (w && kind(a) == 2) begin
      m_done = 1'b1;
      m_code = d;
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; inputs are scrambled after
  // acceptance to show they are not re-sampled.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat,
                     output logic dn);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
    lat = 0; rd = 32'd0; e = 1'b0; dn = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k; rd = rdata; e = err; dn = done;
        break;
      end
      if (rdata !== 32'd0 || err !== 1'b0) stray++;
    end
  endtask

  initial begin
    logic [31:0] rd, a, d, c [2];
    logic        e, w, dn;
    int          lat, got, t [2], idx;

    for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
    m_done = 1'b0; m_code = 32'd0;

    vecs[0]  = '{1'b1, 32'h10,  32'h1234_5678, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,         1'b0, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h13,  32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,         1'b0, 32'h1234_5678};
    vecs[4]  = '{1'b0, 32'h100, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h800, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h7F8, 32'h1000,      1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h7F8, 32'h0,         1'b0, 32'h1000};
    vecs[8]  = '{1'b1, 32'h7F8, 32'h7,         1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h7F8, 32'h0,         1'b0, 32'h7};
    vecs[10] = '{1'b1, 32'h7FC, 32'h55,        1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'hFC,  32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'hFC,  32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[13] = '{1'b0, 32'hFE,  32'h0,         1'b1, 32'h0};

    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_code", done_code, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    reset = 1'b0;

    // Directed table on the WAIT_CYCLES=2 instance.
    for (int i = 0; i < 14; i++) begin
      txn(vecs[i].w, vecs[i].a, vecs[i].d, rd, e, lat, dn);
      $display("vec %0d: we=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
               i, vecs[i].w, vecs[i].a, vecs[i].d, lat, e, rd);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_done_at_ready", i), {31'd0, dn}, {31'd0, m_done});
      model_apply(vecs[i].w, vecs[i].a, vecs[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, m_done});
      chk($sformatf("vec%0d_done_code", i), done_code, m_code);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      w = 1'(($urandom & 1));
      d = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: a = 32'($urandom_range(0, 63)) * 4;
        3:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        4:       a = 32'h7F8;
        default: a = w ? 32'h7FC : 32'h100 + 32'($urandom_range(0, 100)) * 4;
      endcase
      txn(w, a, d, rd, e, lat, dn);
      $display("rnd %0d: we=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
               i, w, a, d, lat, e, rd);
      chk("rnd_lat", lat, 3);
      chk("rnd_err", {31'd0, e}, (kind(a) == 0) ? 32'd1 : 32'd0);
      if (w || kind(a) == 0) chk("rnd_rdata_zero", rd, 32'd0);
      else if (kind(a) == 2) chk("rnd_mbox", rd, m_code);
      else if (kind(a) == 1 && m_val[a / 4]) chk("rnd_ram", rd, m_mem[a / 4]);
      model_apply(w, a, d);
      @(negedge clk);
      chk("rnd_done", {31'd0, done}, {31'd0, m_done});
      chk("rnd_done_code", done_code, m_code);
    end
    chk("idle_outputs_quiet", stray, 0);

    // Zero-wait-state instance: latency, mailbox, back-to-back counter loads.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h7F8; wdata0 = 32'h0000_BEEF;
    @(negedge clk);
    req0 = 1'b0;
    $display("w0 store mbox: ready=%0d err=%0d done=%0d", ready0, err0, done0);
    chk("w0_ready_next_cycle", {31'd0, ready0}, 32'd1);
    chk("w0_err", {31'd0, err0}, 32'd0);
    chk("w0_done_at_ready", {31'd0, done0}, 32'd0);
    @(negedge clk);
    chk("w0_done", {31'd0, done0}, 32'd1);
    chk("w0_done_code", done_code0, 32'h0000_BEEF);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h7FC;
    got = 0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      @(negedge clk);
      if (ready0) begin
        c[got] = rdata0; t[got] = k; got++;
      end
    end
    req0 = 1'b0;
    $display("w0 counter loads: n=%0d c0=%h c1=%h", got, c[0], c[1]);
    chk("w0_two_responses", got, 2);
    chk("w0_cnt_delta", c[1] - c[0], 32'd2);
    chk("w0_throughput", t[1] - t[0], 2);

    // Reset while a store sits in WAIT: not committed, outputs back to reset.
    txn(1'b1, 32'h20, 32'h55AA_55AA, rd, e, lat, dn);
    model_apply(1'b1, 32'h20, 32'h55AA_55AA);
    chk("pre_store_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wait_done", {31'd0, done}, 32'd0);
    chk("rst_wait_done_code", done_code, 32'd0);
    chk("rst_wait_done0", {31'd0, done0}, 32'd0);
    got = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready || err || rdata != 32'd0) got++;
    end
    reset = 1'b0;
    m_done = 1'b0; m_code = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready) got++;
    end
    chk("rst_wait_no_ready", got, 0);
    txn(1'b0, 32'h20, 32'h0, rd, e, lat, dn);
    $display("post-reset load 0x20: lat=%0d err=%0d rdata=%h", lat, e, rd);
    chk("rst_wait_ram_kept", rd, 32'h55AA_55AA);
    chk("rst_wait_lat", lat, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
